jpeg_bit_packer: RTL and testbench

JPEG_BIT_PACKER -- requirements
Module: jpeg_bit_packer

---
 rtl/jpeg_bit_packer.sv | 138 +++++++++++++
 tb/tb_jpeg_bit_packer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_bit_packer.sv
// JPEG entropy-coded segment packer: appends variable-length codes MSB-first into a
// 32-bit accumulator, emits bytes with 0xFF/0x00 stuffing, and pads/drains on flush.
module jpeg_bit_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        code_valid_i,
  input  logic [15:0] code_bits_i,
  input  logic [4:0]  code_len_i,
  output logic        code_ready_o,
  input  logic        flush_i,
  output logic        byte_valid_o,
  output logic [7:0]  byte_data_o,
  input  logic        byte_ready_i,
  output logic        flush_done_o
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PAD   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        stuff_q, stuff_d;
  logic        byte_valid_q, byte_valid_d;
  logic [7:0]  byte_data_q, byte_data_d;

  logic [4:0]  app_len_s;
  logic [15:0] app_bits_s;
  logic        free_s;
  logic        accept_s;

  assign code_ready_o = (state_q == S_RUN) && (cnt_q <= 6'd16) && !stuff_q && !rst_i;
  assign free_s       = !byte_valid_q || byte_ready_i;
  assign accept_s     = code_valid_i && code_ready_o;
  assign byte_valid_o = byte_valid_q;
  assign byte_data_o  = byte_data_q;
  assign flush_done_o = (state_q == S_DONE);

  // Clamped length and masked code bits of the accepted code; zero when nothing is taken.
  always_comb begin
    app_len_s  = 5'd0;
    app_bits_s = 16'h0000;
    if (accept_s) begin
      app_len_s  = (code_len_i > 5'd16) ? 5'd16 : code_len_i;
      app_bits_s = code_bits_i & (16'hFFFF >> (5'd16 - app_len_s));
    end else begin
      app_len_s  = 5'd0;
    end
  end

  // Byte extraction, code append, flush padding and flush sequencing.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    stuff_d      = stuff_q;
    byte_valid_d = byte_valid_q;
    byte_data_d  = byte_data_q;

    if (free_s) begin
      if (stuff_q) begin
        byte_valid_d = 1'b1;
        byte_data_d  = 8'h00;
        stuff_d      = 1'b0;
      end else if (cnt_q >= 6'd8) begin
        byte_valid_d = 1'b1;
        byte_data_d  = acc_q[31:24];
        acc_d        = {acc_q[23:0], 8'h00};
        cnt_d        = cnt_q - 6'd8;
        stuff_d      = (acc_q[31:24] == 8'hFF);
      end else begin
        byte_valid_d = 1'b0;
      end
    end else begin
      byte_valid_d = byte_valid_q;
    end

    // New bits land directly below whatever survives this cycle's extraction.
    acc_d = acc_d | ({16'h0000, app_bits_s} << (6'd32 - cnt_d - {1'b0, app_len_s}));
    cnt_d = cnt_d + {1'b0, app_len_s};

    case (state_q)
      S_RUN: begin
        if (flush_i) begin
          state_d = S_PAD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_PAD: begin
        if (cnt_d[2:0] != 3'd0) begin
          acc_d = acc_d | ({24'h000000, 8'hFF >> cnt_d[2:0]} << (6'd24 - {cnt_d[5:3], 3'b000}));
          cnt_d = {cnt_d[5:3], 3'b000} + 6'd8;
        end else begin
          cnt_d = cnt_d;
        end
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((cnt_q == 6'd0) && !stuff_q && !byte_valid_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_RUN;
      acc_q        <= 32'h0000_0000;
      cnt_q        <= 6'd0;
      stuff_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      stuff_q      <= stuff_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
    end
  end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Self-checking bench for jpeg_bit_packer: directed scenarios plus randomized traffic
// checked against a bit-queue reference model.
module tb_jpeg_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        code_valid;
  logic [15:0] code_bits;
  logic [4:0]  code_len;
  logic        code_ready_o;
  logic        flush;
  logic        byte_valid_o;
  logic [7:0]  byte_data_o;
  logic        byte_ready;
  logic        flush_done_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  bit         bits_q[$];
  bit         m_flushing = 1'b0;

  jpeg_bit_packer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .code_valid_i (code_valid),
    .code_bits_i  (code_bits),
    .code_len_i   (code_len),
    .code_ready_o (code_ready_o),
    .flush_i      (flush),
    .byte_valid_o (byte_valid_o),
    .byte_data_o  (byte_data_o),
    .byte_ready_i (byte_ready),
    .flush_done_o (flush_done_o)
  );

  always #5 clk = ~clk;

  function automatic void model_bytes();
    logic [7:0] b;
    while (bits_q.size() >= 8) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], bits_q.pop_front()};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endfunction

  function automatic void model_push(input logic [15:0] b, input logic [4:0] l);
    int n;
    n = (l > 5'd16) ? 16 : int'(l);
    for (int i = n - 1; i >= 0; i--) bits_q.push_back(b[i]);
    model_bytes();
  endfunction

  function automatic void model_pad();
    while ((bits_q.size() % 8) != 0) bits_q.push_back(1'b1);
    model_bytes();
  endfunction

  // Reference model follows the handshakes; output bytes are captured as consumed.
  always @(posedge clk) begin
    if (rst) begin
      bits_q.delete();
      m_flushing <= 1'b0;
    end else begin
      if (byte_valid_o && byte_ready) obs_q.push_back(byte_data_o);
      if (code_valid && code_ready_o) model_push(code_bits, code_len);
      if (flush && !m_flushing) begin
        model_pad();
        m_flushing <= 1'b1;
      end else if (flush_done_o) begin
        m_flushing <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input int n);
    code_valid = 1'b0;
    flush      = 1'b0;
    byte_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send(input logic [15:0] b, input logic [4:0] l);
    int waited = 0;
    code_bits  = b;
    code_len   = l;
    code_valid = 1'b1;
    while (!code_ready_o && waited < 100) begin
      tick();
      waited++;
    end
    n_checks++;
    if (!code_ready_o) begin
      n_fail++;
      $display("FAIL send_timeout: code_ready=%b after %0d cycles, required 1", code_ready_o, waited);
    end else begin
      tick();
    end
    code_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (flush_done_o) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks += 4;
    if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_byte_valid: got %b, required 0", byte_valid_o); end
    if (byte_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_byte_data: got %h, required 00", byte_data_o); end
    if (flush_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done: got %b, required 0", flush_done_o); end
    if (code_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_code_ready: got %b, required 0", code_ready_o); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (code_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_code_ready: got %b, required 1", code_ready_o); end
  endtask

  task automatic test_basic();
    logic [7:0] want[$];
    want = '{8'hBF};
    obs_q.delete(); exp_q.delete();
    byte_ready = 1'b1;
    send(16'h0005, 5'd3);
    send(16'h001F, 5'd5);
    n_checks++;
    if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: byte_valid=%b, required 0", byte_valid_o); end
    tick();
    n_checks += 2;
    if (byte_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_latency: byte_valid=%b, required 1", byte_valid_o); end
    if (byte_data_o !== 8'hBF) begin n_fail++; $display("FAIL basic_data: got %h, required bf", byte_data_o); end
    run_idle(5);
    n_checks++;
    if (obs_q.size() != want.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d bytes, required %0d", obs_q.size(), want.size());
    end else foreach (want[i]) begin
      n_checks++;
      if (obs_q[i] !== want[i]) begin n_fail++; $display("FAIL basic_byte[%0d]: got %h, required %h", i, obs_q[i], want[i]); end
    end
  endtask

  task automatic test_stuffing();
    logic [7:0] want[$];
    want = '{8'hFF, 8'h00, 8'h12};
    obs_q.delete(); exp_q.delete();
    send(16'h00FF, 5'd8);
    send(16'h0012, 5'd8);
    run_idle(8);
    n_checks++;
    if (obs_q.size() != want.size()) begin
      n_fail++; $display("FAIL stuff_count: got %0d bytes, required %0d", obs_q.size(), want.size());
    end else foreach (want[i]) begin
      n_checks++;
      if (obs_q[i] !== want[i]) begin n_fail++; $display("FAIL stuff_byte[%0d]: got %h, required %h", i, obs_q[i], want[i]); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] want[$];
    bit seen;
    for (int t = 0; t < 2; t++) begin
      want = (t == 0) ? '{8'h7F} : '{8'hFF, 8'h00};
      obs_q.delete(); exp_q.delete();
      send((t == 0) ? 16'h0000 : 16'h0001, 5'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_done(seen);
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL flush_done_%0d: pulse seen=%b, required 1", t, seen); end
      tick();
      n_checks++;
      if (flush_done_o !== 1'b0) begin n_fail++; $display("FAIL flush_pulse_width_%0d: got %b, required 0", t, flush_done_o); end
      n_checks++;
      if (obs_q.size() != want.size()) begin
        n_fail++; $display("FAIL flush_count_%0d: got %0d bytes, required %0d", t, obs_q.size(), want.size());
      end else foreach (want[i]) begin
        n_checks++;
        if (obs_q[i] !== want[i]) begin n_fail++; $display("FAIL flush_byte_%0d[%0d]: got %h, required %h", t, i, obs_q[i], want[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] want[$];
    want = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
    obs_q.delete(); exp_q.delete();
    byte_ready = 1'b0;
    code_bits  = 16'hA5A5;
    code_len   = 5'd16;
    code_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        n_checks += 2;
        if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_first_valid: got %b, required 0", byte_valid_o); end
        if (code_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b, required 1", code_ready_o); end
      end else begin
        n_checks += 3;
        if (byte_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b, required 1", k, byte_valid_o); end
        if (byte_data_o !== 8'hA5) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h, required a5", k, byte_data_o); end
        if (code_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop[%0d]: got %b, required 0", k, code_ready_o); end
      end
    end
    run_idle(10);
    n_checks++;
    if (obs_q.size() != want.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d bytes, required %0d", obs_q.size(), want.size());
    end else foreach (want[i]) begin
      n_checks++;
      if (obs_q[i] !== want[i]) begin n_fail++; $display("FAIL bp_byte[%0d]: got %h, required %h", i, obs_q[i], want[i]); end
    end
  endtask

  task automatic test_code_len();
    logic [7:0] want[$];
    bit seen;
    want = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    obs_q.delete(); exp_q.delete();
    send(16'($urandom), 5'd0);
    run_idle(4);
    n_checks += 2;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL len0_bytes: got %0d bytes, required 0", obs_q.size()); end
    if (code_ready_o !== 1'b1) begin n_fail++; $display("FAIL len0_ready: got %b, required 1", code_ready_o); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done(seen);
    n_checks += 2;
    if (!seen) begin n_fail++; $display("FAIL empty_flush_done: seen=%b, required 1", seen); end
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL empty_flush_bytes: got %0d bytes, required 0", obs_q.size()); end
    send(16'hFFFF, 5'd20);
    run_idle(8);
    n_checks++;
    if (obs_q.size() != want.size()) begin
      n_fail++; $display("FAIL len_clamp_count: got %0d bytes, required %0d", obs_q.size(), want.size());
    end else foreach (want[i]) begin
      n_checks++;
      if (obs_q[i] !== want[i]) begin n_fail++; $display("FAIL len_clamp_byte[%0d]: got %h, required %h", i, obs_q[i], want[i]); end
    end
  endtask

  task automatic test_mid_reset();
    obs_q.delete(); exp_q.delete();
    send(16'h0016, 5'd5);
    rst = 1'b1;
    #1;
    n_checks += 2;
    if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", byte_valid_o); end
    if (code_ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b, required 0", code_ready_o); end
    tick();
    rst = 1'b0;
    run_idle(5);
    n_checks += 2;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_bytes: got %0d bytes, required 0", obs_q.size()); end
    if (byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_valid: got %b, required 0", byte_valid_o); end
    send(16'h003C, 5'd8);
    run_idle(5);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL midrst_after_count: got %0d bytes, required 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== 8'h3C) begin n_fail++; $display("FAIL midrst_after_byte: got %h, required 3c", obs_q[0]); end
    end
  endtask

  task automatic test_random();
    bit         seen;
    bit         stall;
    logic [7:0] held;
    obs_q.delete(); exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      code_valid = 1'($urandom_range(0, 1));
      code_bits  = 16'($urandom);
      code_len   = 5'($urandom_range(0, 20));
      byte_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      stall      = byte_valid_o && !byte_ready;
      held       = byte_data_o;
      tick();
      if (stall) begin
        n_checks++;
        if (byte_valid_o !== 1'b1 || byte_data_o !== held) begin
          n_fail++; $display("FAIL rand_hold[%0d]: got valid=%b data=%h, required valid=1 data=%h", c, byte_valid_o, byte_data_o, held);
        end
      end
    end
    run_idle(1);
    for (int i = 0; i < 200 && m_flushing; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rand_flush_done: seen=%b, required 1", seen); end
    run_idle(2);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d bytes, required %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst        = 1'b1;
    code_valid = 1'b0;
    code_bits  = 16'h0000;
    code_len   = 5'd0;
    flush      = 1'b0;
    byte_ready = 1'b1;
    test_reset();
    test_basic();
    test_stuffing();
    test_flush();
    test_backpressure();
    test_code_len();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
